// File: rtl/dmem_resp.sv
// Memory-side responder for the CPU load/store handshake. It accepts one request at a time, inserts
// WAIT_CYCLES wait states, commits a byte-enabled write or a word read, and holds the response until it is acknowledged.
// Define DMEM_RESP_STATS_EN to add saturating access counters (stat_rd, stat_wr, stat_err).
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; req_ready=1 once reset is released
// S_WAIT | request captured, counting down wait states
// S_RESP | access committed, response held until rsp_ready
module dmem_resp #(
  parameter int              WIDTH       = 32,
  parameter int              DEPTH       = 1024,
  parameter int              WAIT_CYCLES = 2,
  parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [15:0]        stat_rd,
  output logic [15:0]        stat_wr,
  output logic [15:0]        stat_err
`endif
);

  localparam int NB = WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0] SPAN = (WIDTH+1)'(DEPTH * NB);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              accept, commit, rsp_done;

  logic              hold_we, hold_err;
  logic [AW-1:0]     hold_idx;
  logic [WIDTH-1:0]  hold_wdata;
  logic [NB-1:0]     hold_be;

  logic              cmt_we, cmt_err;
  logic [AW-1:0]     cmt_idx;
  logic [WIDTH-1:0]  cmt_wdata;
  logic [NB-1:0]     cmt_be;

  logic [WIDTH-1:0]  offset;
  logic              dec_err;
  logic [AW-1:0]     dec_idx;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Address decode, captured only on the accept edge.
  assign offset  = req_addr - BASE_ADDR;
  assign dec_err = (req_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN) ||
                   ((req_addr & WIDTH'(NB - 1)) != '0);
  assign dec_idx = AW'(offset >> BW);

  assign req_ready = (state == S_IDLE) && rst;
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    rsp_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit   = 1'b1;
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          commit   = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so it must use the live request.
  always_comb begin
    cmt_we    = hold_we;
    cmt_err   = hold_err;
    cmt_idx   = hold_idx;
    cmt_wdata = hold_wdata;
    cmt_be    = hold_be;
    if (state == S_IDLE) begin
      cmt_we    = req_we;
      cmt_err   = dec_err;
      cmt_idx   = dec_idx;
      cmt_wdata = req_wdata;
      cmt_be    = req_be;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept && (WAIT_CYCLES != 0))
        cnt <= 4'(WAIT_CYCLES);
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_we    <= 1'b0;
      hold_err   <= 1'b0;
      hold_idx   <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
    end else if (accept) begin
      hold_we    <= req_we;
      hold_err   <= dec_err;
      hold_idx   <= dec_idx;
      hold_wdata <= req_wdata;
      hold_be    <= req_be;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (!cmt_we && !cmt_err) ? mem[cmt_idx] : '0;
      rsp_err   <= cmt_err;
    end else if (rsp_done) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  // Storage is not reset; writes happen only on a clean commit.
  always_ff @(posedge clk) begin
    if (commit && cmt_we && !cmt_err) begin
      for (int i = 0; i < NB; i++) begin
        if (cmt_be[i])
          mem[cmt_idx][i*8 +: 8] <= cmt_wdata[i*8 +: 8];
      end
    end
  end

`ifdef DMEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rd  <= 16'd0;
      stat_wr  <= 16'd0;
      stat_err <= 16'd0;
    end else if (rsp_done) begin
      if (rsp_err) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else if (hold_we) begin
        if (stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
      end else begin
        if (stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with two wait states, one with none.
// The request fields are shared; each instance has its own req_valid.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        va = 1'b0, vz = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b1;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
`ifdef DMEM_RESP_STATS_EN
  logic [15:0] a_stat_rd, a_stat_wr, a_stat_err;
  logic [15:0] z_stat_rd, z_stat_wr, z_stat_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_resp #(.WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
`ifdef DMEM_RESP_STATS_EN
    , .stat_rd(a_stat_rd), .stat_wr(a_stat_wr), .stat_err(a_stat_err)
`endif
  );

  dmem_resp #(.WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_z (
    .clk(clk), .rst(rst), .req_valid(vz), .req_ready(z_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_RESP_STATS_EN
    , .stat_rd(z_stat_rd), .stat_wr(z_stat_wr), .stat_err(z_stat_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed timeout expected response", tag);
  endtask

  // One full access with rsp_ready high; lat counts negedges from the accept edge to rsp_valid.
  task automatic access(input bit z, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; rsp_ready = 1'b1;
    if (z) vz = 1'b1; else va = 1'b1;
    guard = 0;
    while (!(z ? z_req_ready : a_req_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) timeout("req_ready_wait");
    @(negedge clk);
    va = 1'b0; vz = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD; req_be = 4'hF; req_we = ~we;
    lat = 1;
    while (!(z ? z_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) timeout("rsp_valid_wait");
    rdata = z ? z_rsp_rdata : a_rsp_rdata;
    err   = z ? z_rsp_err : a_rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    // Reset state
    #2;
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(a_req_ready), 32'd1);

    // Full write then read
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr10_lat", 32'(lat), 32'd3);
    chk("wr10_err", 32'(er), 32'd0);
    chk("wr10_rdata", rd, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_lat", 32'(lat), 32'd3);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", 32'(er), 32'd0);

    // Byte enables
    access(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_be_data", rd, 32'hDE22BE44);

    // Address errors
    access(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    access(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'h0);
    chk("misalign_lat", 32'(lat), 32'd3);
    access(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_rdata", rd, 32'h0);
    access(0, 1'b1, 32'h1000, 32'h5, 4'hF, rd, er, lat);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_rdata", rd, 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("rd0_data", rd, 32'hA5A5A5A5);
    chk("rd0_err", 32'(er), 32'd0);
    access(0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    chk("last_word_err", 32'(er), 32'd0);

    // Write with no byte enables is a clean no-op
    access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("be0_err", 32'(er), 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("be0_data", rd, 32'hDE22BE44);

    // Backpressure with a second request held on req_valid
    @(negedge clk);
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; va = 1'b1;
    @(negedge clk);
    req_addr = 32'h0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) timeout("bp_rsp_valid_wait");
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_rdata", a_rsp_rdata, 32'hDE22BE44);
      chk("bp_req_ready", 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", 32'(a_rsp_valid), 32'd0);
    chk("bp_after_hs_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    chk("bp_second_accepted", 32'(a_req_ready), 32'd0);
    va = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) timeout("bp2_rsp_valid_wait");
    chk("bp2_lat", 32'(lat), 32'd3);
    chk("bp2_data", a_rsp_rdata, 32'hA5A5A5A5);

    // Reset while an uncommitted write sits in WAIT
    access(0, 1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(a_req_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rel_ready", 32'(a_req_ready), 32'd1);
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_rd20", rd, 32'h0);

    // Zero wait states, back-to-back
    access(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat);
    chk("z_wr40_lat", 32'(lat), 32'd1);
    access(1, 1'b1, 32'h44, 32'h01020304, 4'hF, rd, er, lat);
    chk("z_wr44_lat", 32'(lat), 32'd1);
    access(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("z_rd40_lat", 32'(lat), 32'd1);
    chk("z_rd40_data", rd, 32'hCAFEF00D);
    access(1, 1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat);
    chk("z_rd44_data", rd, 32'h01020304);
    access(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("z_rd40b_data", rd, 32'hCAFEF00D);
    access(1, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    chk("z_oor_err", 32'(er), 32'd1);
    chk("z_oor_lat", 32'(lat), 32'd1);
    @(negedge clk);
`ifdef DMEM_RESP_STATS_EN
    chk("z_stat_rd", 32'(z_stat_rd), 32'd3);
    chk("z_stat_wr", 32'(z_stat_wr), 32'd2);
    chk("z_stat_err", 32'(z_stat_err), 32'd1);
    chk("a_stat_rd", 32'(a_stat_rd), 32'd1);
    chk("a_stat_wr", 32'(a_stat_wr), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
